// File: rtl/clock_monitor.sv
// clock_monitor
// Synchronises a slow, asynchronous square wave into clk_in, emits one tick
// per rising edge and measures each period in clk_in cycles. The period is
// checked against EXPECTED_PERIOD +/- TOLERANCE. The result drives a small
// ACQUIRE / LOCKED / LOST health FSM. All outputs are registered.
module clock_monitor #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned EXPECTED_PERIOD = 100000,
    parameter int unsigned TOLERANCE       = 16,
    parameter int unsigned TIMEOUT         = 200000,
    parameter int unsigned LOCK_COUNT      = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic             sig_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TOL_LO    = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [CNT_W-1:0]  TOL_HI    = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCKED,
        LOST
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              s1;
    logic              s2;
    logic              s3;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_new;
    logic              have_ref;
    logic              meas;
    logic              in_tol;
    logic              timeout_hit;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;
    logic [GOOD_W-1:0] good_nxt;

    // Three-flop synchroniser; the third flop is the edge-detect history.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Rising-edge detect, candidate period and the event qualifiers.
    always_comb begin
        rise        = s2 & ~s3;
        period_new  = cnt + CNT_ONE;
        meas        = rise & have_ref;
        in_tol      = (period_new >= TOL_LO) && (period_new <= TOL_HI);
        // A rise on the threshold cycle takes priority over the timeout.
        timeout_hit = ~rise && (cnt == TO_LAST);
        good_inc    = good + GOOD_ONE;
    end

    // Cycle counter: cleared on each rise, otherwise counts up and saturates.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Reference flag: a period is only measured between two observed edges.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            have_ref <= 1'b0;
        end else if (timeout_hit) begin
            have_ref <= 1'b0;
        end else if (rise) begin
            have_ref <= 1'b1;
        end
    end

    // Health FSM state and good-period counter registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= ACQUIRE;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Health FSM next-state logic.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        if (timeout_hit) begin
            state_nxt = LOST;
            good_nxt  = '0;
        end else begin
            unique case (state)
                ACQUIRE: begin
                    if (meas) begin
                        if (in_tol) begin
                            good_nxt = good_inc;
                            if (good_inc == GOOD_LOCK) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            good_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (meas && !in_tol) begin
                        state_nxt = ACQUIRE;
                        good_nxt  = '0;
                    end
                end
                LOST: begin
                    // have_ref is clear here, so this edge yields no period.
                    if (rise) begin
                        state_nxt = ACQUIRE;
                    end
                end
                default: begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    // Registered outputs; status follows the next state so it moves on the
    // same edge as the period_valid or timeout that caused it.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sig_tick     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            sig_tick     <= rise;
            period_valid <= meas;
            if (meas) begin
                period <= period_new;
            end
            locked <= (state_nxt == LOCKED);
            lost   <= (state_nxt == LOST);
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: stimulus pushes one expected entry
// per rising edge it drives; a monitor pops and compares on every sig_tick.
module tb_clock_monitor;

    localparam int unsigned CNT_W = 16;

    logic             clk_in;
    logic             reset;
    logic             sig_in;
    logic             sig_tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    int unsigned last_c0  = 0;

    typedef struct {
        int unsigned cyc;
        bit          valid;
        int unsigned per;
        bit          lk;
        bit          ls;
    } tick_exp_t;

    tick_exp_t exp_q[$];
    tick_exp_t mon_e;

    clock_monitor #(
        .CNT_W          (CNT_W),
        .EXPECTED_PERIOD(20),
        .TOLERANCE      (2),
        .TIMEOUT        (50),
        .LOCK_COUNT     (4)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .sig_tick    (sig_tick),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sig_tick"}, sig_tick, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_period_valid"}, period_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lost"}, lost, 0);
    endtask

    // Called at a negedge: raise sig_in, expect a tick 3 edges later, then
    // hold high for hi cycles and low for lo cycles.
    task automatic pulse(input int unsigned hi, input int unsigned lo, input bit v,
                         input int unsigned p, input bit lk, input bit ls);
        tick_exp_t e;
        e.cyc   = cyc + 3;
        e.valid = v;
        e.per   = p;
        e.lk    = lk;
        e.ls    = ls;
        exp_q.push_back(e);
        last_c0 = cyc;
        sig_in  = 1'b1;
        repeat (hi) @(negedge clk_in);
        if (lo > 0) begin
            sig_in = 1'b0;
            repeat (lo) @(negedge clk_in);
        end
    endtask

    // Monitor: every tick consumes one expected entry.
    always @(negedge clk_in) begin
        if (sig_tick) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", sig_tick, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_cycle", cyc, mon_e.cyc);
                check("tick_period_valid", period_valid, mon_e.valid);
                if (mon_e.valid) check("tick_period", period, mon_e.per);
                check("tick_locked", locked, mon_e.lk);
                check("tick_lost", lost, mon_e.ls);
            end
        end else if (period_valid) begin
            check("valid_without_tick", period_valid, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;

        // Reset held while sig_in toggles: outputs stay clear.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            if (i % 3 == 0) sig_in = ~sig_in;
            check_zero("in_reset");
        end
        sig_in = 1'b0;
        reset  = 1'b0;
        repeat (10) @(negedge clk_in);
        check_zero("idle_after_reset");

        // Steady 20-cycle wave: first edge gives no period, lock on 5th tick.
        pulse(10, 10, 0, 0,  0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 1, 0);
        // Tolerance edges while locked: 18 and 22 hold, 23 drops lock.
        pulse(9,  9,  1, 20, 1, 0);
        pulse(11, 11, 1, 18, 1, 0);
        pulse(12, 11, 1, 22, 1, 0);
        pulse(10, 10, 1, 23, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 1, 0);

        // Timeout: hold low after a tick, LOST 50 cycles after that rise.
        pulse(10, 0, 1, 20, 1, 0);
        sig_in = 1'b0;
        while (cyc < last_c0 + 52) @(negedge clk_in);
        check("lost_before_timeout", lost, 0);
        check("locked_before_timeout", locked, 1);
        @(negedge clk_in);
        check("lost_at_timeout", lost, 1);
        check("locked_at_timeout", locked, 0);
        repeat (7) @(negedge clk_in);
        pulse(10, 10, 0, 0,  0, 0);
        pulse(10, 40, 1, 20, 0, 0);

        // Rise exactly on the timeout threshold: period 50, no LOST, good cleared.
        pulse(10, 10, 1, 50, 0, 0);
        check("lost_after_simultaneous", lost, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 1, 0);
        pulse(10, 10, 1, 20, 1, 0);

        // Asynchronous reset while locked with sig_in high.
        pulse(5, 0, 1, 20, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        pulse(10, 10, 0, 0,  0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 0, 0);
        pulse(10, 10, 1, 20, 1, 0);

        repeat (5) @(negedge clk_in);
        check("all_ticks_seen", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
